dcd_scan_vars: RTL and testbench

- Sequential decision finder for the SAT engine state list. Scans a parametrised number of variables in fixed-size chunks, one chunk per clock, and returns the next free (unassigned) variable to branch on.
- Supports first-free and round-robin priority, uses a start/valid/ack handshake, and can be aborted.
- Sits between the state list and the decision/level controller, as the multi-cycle successor to the flat combinational free-variable decode.

---
 rtl/dcd_scan_vars_if.sv | 28 ++
 rtl/dcd_scan_vars.sv | 174 +++++++++++++++++
 tb/tb_dcd_scan_vars.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcd_scan_vars_if.sv
// Request/result bundle for the chunked free-variable scanner.
// The requester drives start/mode/value/abort/ack; the scanner returns the result.
interface dcd_scan_vars_if #(
    parameter int NUM_VARS = 32,
    parameter int WIDTH    = 3,
    parameter int IDX_W    = $clog2(NUM_VARS)
);
    logic                      start_i;
    logic                      mode_i;
    logic [NUM_VARS*WIDTH-1:0] value_i;
    logic                      abort_i;
    logic                      ack_i;
    logic                      busy_o;
    logic                      valid_o;
    logic                      found_o;
    logic [IDX_W-1:0]          index_o;
    logic [NUM_VARS-1:0]       onehot_o;

    modport master (
        output start_i, mode_i, value_i, abort_i, ack_i,
        input  busy_o, valid_o, found_o, index_o, onehot_o
    );

    modport slave (
        input  start_i, mode_i, value_i, abort_i, ack_i,
        output busy_o, valid_o, found_o, index_o, onehot_o
    );
endinterface

// File: rtl/dcd_scan_vars.sv
// Multi-cycle decision finder: scans CHUNK variables per clock for the next
// free variable, first-free or round-robin after the last accepted decision.
module dcd_scan_vars #(
    parameter int NUM_VARS = 32,
    parameter int WIDTH    = 3,
    parameter int CHUNK    = 8,
    parameter int IDX_W    = $clog2(NUM_VARS)
) (
    input logic           clk,
    input logic           rst_n,
    dcd_scan_vars_if.slave bus
);
    localparam int NCH = NUM_VARS / CHUNK;
    localparam int SW  = $clog2(NCH + 1);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CB  = $clog2(CHUNK);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e              state_q, state_d;
    logic [NUM_VARS-1:0] free_q, free_d, free_in;
    logic [NUM_VARS-1:0] onehot_q, onehot_d;
    logic                mode_q, mode_d;
    logic [SW-1:0]       step_q, step_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic                valid_q, valid_d;
    logic                found_q, found_d;

    logic [CW-1:0]       c0;
    logic [SW:0]         csum;
    logic [CW-1:0]       chunk;
    logic [CHUNK-1:0]    cand;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                last_step;
    logic                mask_lo, mask_hi;
    logic                unused_value;

    function automatic logic [IDX_W-1:0] var_idx(input logic [CW-1:0] c,
                                                 input int j);
        return IDX_W'(int'(c) * CHUNK + j);
    endfunction

    // Only the two-bit value code matters; the upper bits are don't-care.
    assign unused_value = ^bus.value_i;

    always_comb begin
        free_in = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            free_in[k] = (bus.value_i[k*WIDTH +: 2] == 2'b00);
        end
    end

    assign c0 = CW'(last_q >> CB);

    // Round-robin walks chunks c0, c0+1, ... wrapping once back onto c0.
    always_comb begin
        csum = (SW+1)'(c0) + (SW+1)'(step_q);
        if (csum >= (SW+1)'(NCH)) begin
            csum = csum - (SW+1)'(NCH);
        end
        chunk = mode_q ? CW'(csum) : CW'(step_q);
    end

    assign mask_lo   = mode_q && (step_q == '0);
    assign mask_hi   = mode_q && (step_q == SW'(NCH));
    assign last_step = mode_q ? (step_q == SW'(NCH))
                              : (step_q == SW'(NCH - 1));

    always_comb begin
        cand    = '0;
        hit_idx = '0;
        for (int j = 0; j < CHUNK; j++) begin
            cand[j] = free_q[var_idx(chunk, j)]
                   && !(mask_lo && (var_idx(chunk, j) <= last_q))
                   && !(mask_hi && (var_idx(chunk, j) > last_q));
        end
        for (int j = CHUNK - 1; j >= 0; j--) begin
            if (cand[j]) begin
                hit_idx = var_idx(chunk, j);
            end
        end
    end

    assign hit = |cand;

    always_comb begin
        state_d  = state_q;
        free_d   = free_q;
        mode_d   = mode_q;
        step_d   = step_q;
        last_d   = last_q;
        valid_d  = valid_q;
        found_d  = found_q;
        index_d  = index_q;
        onehot_d = onehot_q;
        if (bus.abort_i) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            found_d  = 1'b0;
            index_d  = '0;
            onehot_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        free_d  = free_in;
                        mode_d  = bus.mode_i;
                        step_d  = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        valid_d  = 1'b1;
                        found_d  = 1'b1;
                        index_d  = hit_idx;
                        onehot_d = NUM_VARS'(1) << hit_idx;
                        state_d  = DONE;
                    end else if (last_step) begin
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
                DONE: begin
                    if (bus.ack_i) begin
                        if (found_q) begin
                            last_d = index_q;
                        end
                        valid_d  = 1'b0;
                        found_d  = 1'b0;
                        index_d  = '0;
                        onehot_d = '0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            free_q   <= '0;
            mode_q   <= 1'b0;
            step_q   <= '0;
            last_q   <= IDX_W'(NUM_VARS - 1);
            valid_q  <= 1'b0;
            found_q  <= 1'b0;
            index_q  <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            free_q   <= free_d;
            mode_q   <= mode_d;
            step_q   <= step_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            found_q  <= found_d;
            index_q  <= index_d;
            onehot_q <= onehot_d;
        end
    end

    assign bus.busy_o   = (state_q != IDLE);
    assign bus.valid_o  = valid_q;
    assign bus.found_o  = found_q;
    assign bus.index_o  = index_q;
    assign bus.onehot_o = onehot_q;
endmodule

// File: tb/tb_dcd_scan_vars.sv
// Scoreboard bench for dcd_scan_vars: a priority-order model predicts
// result and latency per scan, compared when valid_o rises.
module tb_dcd_scan_vars;
    localparam int NV  = 32;
    localparam int W   = 3;
    localparam int CH  = 8;
    localparam int IW  = 5;
    localparam int NCH = NV / CH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcd_scan_vars_if #(.NUM_VARS(NV), .WIDTH(W), .IDX_W(IW)) bus ();

    dcd_scan_vars #(
        .NUM_VARS(NV), .WIDTH(W), .CHUNK(CH), .IDX_W(IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       found;
        logic [4:0] idx;
        int         lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          last_m = NV - 1;
    logic        o_found;
    logic [4:0]  o_idx;
    logic [31:0] o_oh;
    int          o_lat;

    function automatic logic [NV*W-1:0] mkval(input logic [31:0] freem);
        logic [NV*W-1:0] v;
        logic [1:0]      code;
        v = '0;
        for (int k = 0; k < NV; k++) begin
            code = freem[k] ? 2'b00 : 2'((k % 3) + 1);
            v[k*W +: W] = {1'($urandom_range(0, 1)), code};
        end
        return v;
    endfunction

    function automatic exp_t model(input logic mode, input logic [31:0] freem,
                                   input int last);
        exp_t e;
        int   v, vc, c0, st;
        e.found = 1'b0;
        e.idx   = '0;
        e.lat   = mode ? NCH + 2 : NCH + 1;
        c0 = last / CH;
        for (int n = 0; n < NV; n++) begin
            v = mode ? (last + 1 + n) % NV : n;
            if (freem[v] && !e.found) begin
                e.found = 1'b1;
                e.idx   = v[4:0];
                vc = v / CH;
                if (!mode)          st = vc;
                else if (v > last)  st = vc - c0;
                else if (vc < c0)   st = NCH - c0 + vc;
                else                st = NCH;
                e.lat = st + 2;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] oh_of(input exp_t e);
        return e.found ? (32'd1 << e.idx) : 32'd0;
    endfunction

    task automatic wait_valid();
        while (!bus.valid_o && o_lat < 20) begin
            @(negedge clk);
            o_lat++;
        end
        o_found = bus.found_o;
        o_idx   = bus.index_o;
        o_oh    = bus.onehot_o;
    endtask

    task automatic run_scan(input logic mode, input logic [31:0] freem);
        sb.push_back(model(mode, freem, last_m));
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mode_i  = mode;
        bus.value_i = mkval(freem);
        @(negedge clk);
        bus.start_i = 1'b0;
        o_lat = 1;
        wait_valid();
    endtask

    task automatic do_ack(input exp_t e);
        @(negedge clk);
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        if (e.found) last_m = e.idx;
    endtask

    task automatic test_reset();
        total++;
        if ({bus.busy_o, bus.valid_o, bus.found_o, bus.index_o, bus.onehot_o} !== '0) begin
            bad++;
            $display("FAIL por_outputs got b=%b v=%b f=%b i=%0d oh=%h want 0",
                     bus.busy_o, bus.valid_o, bus.found_o, bus.index_o, bus.onehot_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(1'b0, 32'h8000_0000);
        begin
            exp_t e = sb.pop_front();
            do_ack(e);
        end
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b0;
        bus.value_i = mkval(32'h0);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy_o, bus.valid_o, bus.found_o, bus.index_o, bus.onehot_o} !== '0) begin
            bad++;
            $display("FAIL midscan_reset got b=%b v=%b f=%b i=%0d oh=%h want 0",
                     bus.busy_o, bus.valid_o, bus.found_o, bus.index_o, bus.onehot_o);
        end
        last_m = NV - 1;
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(1'b1, 32'hFFFF_FFFF);
        begin
            exp_t e = sb.pop_front();
            total++;
            if (o_lat !== e.lat || o_found !== e.found || o_idx !== e.idx) begin
                bad++;
                $display("FAIL rr_after_reset got lat=%0d f=%b i=%0d want lat=%0d f=%b i=%0d",
                         o_lat, o_found, o_idx, e.lat, e.found, e.idx);
            end
            do_ack(e);
        end
    endtask

    task automatic test_first_free();
        exp_t e;
        run_scan(1'b0, 32'h0008_0000);
        e = sb.pop_front();
        total++;
        if (o_lat !== e.lat || o_found !== e.found || o_idx !== e.idx || o_oh !== oh_of(e)) begin
            bad++;
            $display("FAIL first_free got lat=%0d f=%b i=%0d oh=%h want lat=%0d f=%b i=%0d oh=%h",
                     o_lat, o_found, o_idx, o_oh, e.lat, e.found, e.idx, oh_of(e));
        end
        repeat (3) @(negedge clk);
        total++;
        if (!bus.valid_o || bus.index_o !== 5'd19 || bus.onehot_o !== 32'h0008_0000) begin
            bad++;
            $display("FAIL hold got v=%b i=%0d oh=%h want v=1 i=19 oh=00080000",
                     bus.valid_o, bus.index_o, bus.onehot_o);
        end
        do_ack(e);
        total++;
        if ({bus.busy_o, bus.valid_o, bus.found_o, bus.onehot_o} !== '0) begin
            bad++;
            $display("FAIL post_ack got b=%b v=%b f=%b oh=%h want 0",
                     bus.busy_o, bus.valid_o, bus.found_o, bus.onehot_o);
        end
    endtask

    task automatic test_none_free();
        exp_t e;
        run_scan(1'b0, 32'h0);
        e = sb.pop_front();
        total++;
        if (o_lat !== e.lat || o_found !== 1'b0 || o_idx !== 5'd0 || o_oh !== 32'd0) begin
            bad++;
            $display("FAIL none_free got lat=%0d f=%b i=%0d oh=%h want lat=%0d f=0 i=0 oh=0",
                     o_lat, o_found, o_idx, o_oh, e.lat);
        end
        do_ack(e);
    endtask

    task automatic test_round_robin();
        exp_t e;
        run_scan(1'b1, (32'd1 << 5) | (32'd1 << 19) | (32'd1 << 25));
        e = sb.pop_front();
        total++;
        if (o_lat !== e.lat || o_found !== e.found || o_idx !== e.idx || o_oh !== oh_of(e)) begin
            bad++;
            $display("FAIL rr_step1 got lat=%0d i=%0d want lat=%0d i=%0d",
                     o_lat, o_idx, e.lat, e.idx);
        end
        do_ack(e);
        run_scan(1'b1, (32'd1 << 5) | (32'd1 << 19));
        e = sb.pop_front();
        total++;
        if (o_lat !== e.lat || o_found !== e.found || o_idx !== e.idx || o_oh !== oh_of(e)) begin
            bad++;
            $display("FAIL rr_wrap got lat=%0d i=%0d want lat=%0d i=%0d",
                     o_lat, o_idx, e.lat, e.idx);
        end
        do_ack(e);
    endtask

    task automatic test_rr_revisit();
        exp_t e;
        run_scan(1'b0, 32'h0008_0000);
        e = sb.pop_front();
        do_ack(e);
        run_scan(1'b1, 32'h0008_0000);
        e = sb.pop_front();
        total++;
        if (o_lat !== e.lat || o_found !== e.found || o_idx !== e.idx) begin
            bad++;
            $display("FAIL rr_revisit got lat=%0d f=%b i=%0d want lat=%0d f=%b i=%0d",
                     o_lat, o_found, o_idx, e.lat, e.found, e.idx);
        end
        do_ack(e);
        run_scan(1'b1, 32'h0);
        e = sb.pop_front();
        total++;
        if (o_lat !== e.lat || o_found !== 1'b0 || o_oh !== 32'd0) begin
            bad++;
            $display("FAIL rr_none got lat=%0d f=%b oh=%h want lat=%0d f=0 oh=0",
                     o_lat, o_found, o_oh, e.lat);
        end
        do_ack(e);
    endtask

    task automatic test_abort();
        exp_t e;
        logic seen;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b1;
        bus.value_i = mkval(32'h0);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        seen = bus.valid_o | bus.busy_o;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.valid_o;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_scan got busy/valid=%b want 0", seen);
        end
        run_scan(1'b0, 32'h0000_0080);
        e = sb.pop_front();
        @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        total++;
        if (bus.valid_o !== 1'b0 || bus.found_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_done got v=%b f=%b want 0", bus.valid_o, bus.found_o);
        end
        run_scan(1'b1, (32'd1 << 3) | (32'd1 << 20));
        e = sb.pop_front();
        total++;
        if (o_lat !== e.lat || o_idx !== e.idx || o_found !== e.found) begin
            bad++;
            $display("FAIL abort_keeps_last got lat=%0d i=%0d want lat=%0d i=%0d",
                     o_lat, o_idx, e.lat, e.idx);
        end
        do_ack(e);
    endtask

    task automatic test_ignored_inputs();
        exp_t e;
        logic busy_seen;
        sb.push_back(model(1'b0, 32'h4000_0000, last_m));
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b0;
        bus.value_i = mkval(32'h4000_0000);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.value_i = mkval(32'hFFFF_FFFF);
        o_lat = 1;
        @(negedge clk);
        o_lat++;
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b1;
        @(negedge clk);
        o_lat++;
        bus.start_i = 1'b0;
        wait_valid();
        e = sb.pop_front();
        total++;
        if (o_lat !== e.lat || o_found !== e.found || o_idx !== e.idx || o_oh !== oh_of(e)) begin
            bad++;
            $display("FAIL ignore_busy_start got lat=%0d i=%0d want lat=%0d i=%0d",
                     o_lat, o_idx, e.lat, e.idx);
        end
        do_ack(e);
        busy_seen = bus.busy_o;
        @(negedge clk);
        busy_seen = busy_seen | bus.busy_o;
        total++;
        if (busy_seen !== 1'b0) begin
            bad++;
            $display("FAIL start_not_queued got busy=%b want 0", busy_seen);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        run_scan(1'b0, 32'h0000_1000);
        e = sb.pop_front();
        @(negedge clk);
        bus.ack_i   = 1'b1;
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b0;
        bus.value_i = mkval(32'hFFFF_FFFF);
        @(negedge clk);
        bus.ack_i   = 1'b0;
        bus.start_i = 1'b0;
        last_m = e.idx;
        total++;
        if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL ack_with_start got b=%b v=%b want 0", bus.busy_o, bus.valid_o);
        end
        run_scan(1'b1, (32'd1 << 2) | (32'd1 << 13));
        e = sb.pop_front();
        total++;
        if (o_lat !== e.lat || o_idx !== e.idx || o_found !== e.found) begin
            bad++;
            $display("FAIL restart_after_ack got lat=%0d i=%0d want lat=%0d i=%0d",
                     o_lat, o_idx, e.lat, e.idx);
        end
        do_ack(e);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.mode_i  = 1'b0;
        bus.value_i = '0;
        bus.abort_i = 1'b0;
        bus.ack_i   = 1'b0;
        #2;
        test_reset();
        test_first_free();
        test_none_free();
        test_round_robin();
        test_rr_revisit();
        test_abort();
        test_ignored_inputs();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
